// File: rtl/layer_pkg.sv
// Shared types and sizing helpers for the layer-to-layer serializer.
// Latency and backpressure: not applicable (types and helpers only).
package layer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Index width for an n-entry word counter; at least one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_serializer.sv
// Collects one layer's per-neuron words, then streams them neuron 0 first, one per cycle.
// Latency: word 0 one cycle after the completing edge; no backpressure (downstream always accepts).
module layer_serializer
    import layer_pkg::*;
#(
    parameter int NN        = 10,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] x_in,
    output logic                    o_valid,
    output logic [dataWidth-1:0]    x_out,
    output logic                    busy,
    output logic                    err_overrun,
    output logic                    err_dup
);

    localparam int                IDX_W    = idx_w(NN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NN - 1);
    localparam logic [NN-1:0]     ALL_ONES = {NN{1'b1}};

    ser_state_t                       state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NN-1:0][dataWidth-1:0]     col_data_q, col_data_d;
    logic [NN-1:0][dataWidth-1:0]     sh_data_q, sh_data_d;
    logic [NN-1:0]                    col_mask_q, col_mask_d;
    logic                             col_full_q, col_full_d;
    logic                             o_valid_q, o_valid_d;
    logic [dataWidth-1:0]             x_out_q, x_out_d;
    logic                             busy_q, busy_d;
    logic                             err_overrun_q, err_overrun_d;
    logic                             err_dup_q, err_dup_d;

    logic [NN-1:0]                    cap;
    logic [NN-1:0][dataWidth-1:0]     merged;
    logic                             complete;
    logic                             last_word;
    logic                             sh_free;

    always_comb begin
        cap = col_full_q ? '0 : (i_valid & ~col_mask_q);
        for (int k = 0; k < NN; k++) begin
            merged[k] = cap[k] ? x_in[k*dataWidth +: dataWidth] : col_data_q[k];
        end
        complete  = !col_full_q && ((col_mask_q | cap) == ALL_ONES);
        last_word = (state_q == SHIFT) && (idx_q == LAST_IDX);
        sh_free   = (state_q == IDLE) || last_word;

        state_d       = state_q;
        idx_d         = idx_q;
        sh_data_d     = sh_data_q;
        col_data_d    = merged;
        col_mask_d    = col_mask_q | cap;
        col_full_d    = col_full_q;
        err_dup_d     = err_dup_q | (!col_full_q && (|(i_valid & col_mask_q)));
        err_overrun_d = err_overrun_q | (col_full_q && (|i_valid));

        case (state_q)
            SHIFT: begin
                if (last_word) begin
                    if (col_full_q) begin
                        sh_data_d  = col_data_q;
                        idx_d      = '0;
                        col_full_d = 1'b0;
                        col_mask_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase

        // A freshly completed vector goes straight to the shifter when it is
        // free this edge; otherwise it parks in the collect buffer.
        if (complete) begin
            if (sh_free) begin
                sh_data_d  = merged;
                idx_d      = '0;
                state_d    = SHIFT;
                col_mask_d = '0;
            end else begin
                col_full_d = 1'b1;
            end
        end

        o_valid_d = (state_d == SHIFT);
        x_out_d   = (state_d == SHIFT) ? sh_data_d[idx_d] : x_out_q;
        busy_d    = (state_d == SHIFT) || (col_mask_d != '0) || col_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            sh_data_q     <= '0;
            col_data_q    <= '0;
            col_mask_q    <= '0;
            col_full_q    <= 1'b0;
            o_valid_q     <= 1'b0;
            x_out_q       <= '0;
            busy_q        <= 1'b0;
            err_overrun_q <= 1'b0;
            err_dup_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            sh_data_q     <= sh_data_d;
            col_data_q    <= col_data_d;
            col_mask_q    <= col_mask_d;
            col_full_q    <= col_full_d;
            o_valid_q     <= o_valid_d;
            x_out_q       <= x_out_d;
            busy_q        <= busy_d;
            err_overrun_q <= err_overrun_d;
            err_dup_q     <= err_dup_d;
        end
    end

    assign o_valid     = o_valid_q;
    assign x_out       = x_out_q;
    assign busy        = busy_q;
    assign err_overrun = err_overrun_q;
    assign err_dup     = err_dup_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer: capture, ordering, buffering, errors, reset.
// Output words are logged with their cycle stamp and compared against hand-built streams.
module tb_layer_serializer;

    localparam int NN = 10;
    localparam int DW = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NN-1:0]      i_valid;
    logic [NN*DW-1:0]   x_in;
    logic               o_valid;
    logic [DW-1:0]      x_out;
    logic               busy;
    logic               err_overrun;
    logic               err_dup;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0;

    logic [DW-1:0] words[$];
    int            stamps[$];
    logic [DW-1:0] exp_q[$];

    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .x_in        (x_in),
        .o_valid     (o_valid),
        .x_out       (x_out),
        .busy        (busy),
        .err_overrun (err_overrun),
        .err_dup     (err_dup)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid) begin
            words.push_back(x_out);
            stamps.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input logic [NN-1:0] vmask, input logic [DW-1:0] base);
        i_valid = vmask;
        for (int k = 0; k < NN; k++) x_in[k*DW +: DW] = base + DW'(k);
    endtask

    task automatic idle_in();
        i_valid = '0;
        x_in    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        rst = 1'b0;
        words.delete();
        stamps.delete();
    endtask

    // Stream must match exp_q word for word and run contiguously from t_first.
    task automatic check_stream(input string tag, input int t_first);
        check({tag, "_count"}, words.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < words.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), words[i], exp_q[i]);
            check($sformatf("%s_t%0d", tag, i), stamps[i], t_first + i);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] base);
        for (int k = 0; k < NN; k++) exp_q.push_back(base + DW'(k));
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        check("rst_o_valid", o_valid, 0);
        check("rst_x_out", x_out, 0);
        check("rst_busy", busy, 0);
        check("rst_err_ovr", err_overrun, 0);
        check("rst_err_dup", err_dup, 0);
        rst = 1'b0;

        // All neurons valid in one cycle, word k = k+1.
        words.delete(); stamps.delete(); exp_q.delete();
        t0 = cyc;
        drive_vec('1, 16'd1);
        tick();
        idle_in();
        check("t1_busy_hi", busy, 1);
        repeat (12) tick();
        push_exp(16'd1);
        check_stream("t1", t0 + 1);
        check("t1_o_valid_lo", o_valid, 0);
        check("t1_busy_lo", busy, 0);
        check("t1_x_out_hold", x_out, 16'd10);

        // Staggered: neuron k valid alone at step k.
        words.delete(); stamps.delete(); exp_q.delete();
        for (int k = 0; k < NN; k++) begin
            i_valid = '0;
            i_valid[k] = 1'b1;
            x_in = '0;
            x_in[k*DW +: DW] = 16'h20 + DW'(k);
            t0 = cyc;
            tick();
        end
        idle_in();
        repeat (12) tick();
        push_exp(16'h20);
        check_stream("t2", t0 + 1);
        check("t2_err_ovr", err_overrun, 0);
        check("t2_err_dup", err_dup, 0);

        // Back-to-back vectors: second waits in collect buffer, no gap.
        words.delete(); stamps.delete(); exp_q.delete();
        t0 = cyc;
        drive_vec('1, 16'h30);
        tick();
        drive_vec('1, 16'h100);
        tick();
        idle_in();
        check("t3_busy", busy, 1);
        repeat (22) tick();
        push_exp(16'h30);
        push_exp(16'h100);
        check_stream("t3", t0 + 1);
        check("t3_err_ovr", err_overrun, 0);
        check("t3_busy_lo", busy, 0);

        // Third vector while collect full: dropped, overrun flagged.
        words.delete(); stamps.delete(); exp_q.delete();
        t0 = cyc;
        drive_vec('1, 16'h40);
        tick();
        drive_vec('1, 16'h100);
        tick();
        drive_vec('1, 16'h200);
        tick();
        idle_in();
        repeat (22) tick();
        push_exp(16'h40);
        push_exp(16'h100);
        check_stream("t4", t0 + 1);
        check("t4_err_ovr", err_overrun, 1);
        check("t4_err_dup", err_dup, 0);
        check("t4_busy_lo", busy, 0);

        // Duplicate valid on neuron 3: first value kept.
        do_reset();
        check("t5_ovr_cleared", err_overrun, 0);
        exp_q.delete();
        i_valid = '0; x_in = '0;
        i_valid[3] = 1'b1; x_in[3*DW +: DW] = 16'h33;
        tick();
        check("t5_busy_partial", busy, 1);
        x_in[3*DW +: DW] = 16'hEE;
        tick();
        check("t5_err_dup_set", err_dup, 1);
        drive_vec(~(NN'(1) << 3), 16'h50);
        t0 = cyc;
        tick();
        idle_in();
        repeat (12) tick();
        push_exp(16'h50);
        exp_q[3] = 16'h33;
        check_stream("t5", t0 + 1);
        check("t5_err_dup", err_dup, 1);
        check("t5_err_ovr", err_overrun, 0);

        // Reset during word 4, then a fresh vector.
        do_reset();
        check("t6_dup_cleared", err_dup, 0);
        exp_q.delete();
        t0 = cyc;
        drive_vec('1, 16'h60);
        tick();
        idle_in();
        repeat (4) tick();
        check("t6_word4_vld", o_valid, 1);
        check("t6_word4", x_out, 16'h64);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_o_valid_lo", o_valid, 0);
        check("t6_busy_lo", busy, 0);
        check("t6_x_out_clr", x_out, 0);
        repeat (3) tick();
        for (int k = 0; k < 5; k++) exp_q.push_back(16'h60 + DW'(k));
        check_stream("t6a", t0 + 1);
        words.delete(); stamps.delete(); exp_q.delete();
        t0 = cyc;
        drive_vec('1, 16'h70);
        tick();
        idle_in();
        repeat (12) tick();
        push_exp(16'h70);
        check_stream("t6b", t0 + 1);
        check("t6_err_ovr", err_overrun, 0);
        check("t6_err_dup", err_dup, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
